// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Imported by the loader top and its word assembler.
package loader_pkg;

  localparam int ADDR_W_DEF     = 6;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BYTES,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Little-endian byte-to-word assembler.
// Bytes shift in from the top so byte 0 lands in [7:0].
module word_assembler
  import loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_word;

  // Byte index and shift register; clear drops any partial word
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_en) begin
      r_idx  <= r_idx + 1'b1;
      r_word <= {i_byte, r_word[31:8]};
    end
  end

  assign o_word      = r_word;
  assign o_word_full =
    i_en && (r_idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader for the instruction memory.
// Holds the CPU until N words are written from address 0.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_words_loaded
);

  state_t r_state;
  state_t w_next;

  logic [ADDR_W:0] r_count;
  logic [ADDR_W:0] r_target;
  logic [ADDR_W:0] w_count_inc;
  logic [ADDR_W:0] w_hdr_n;
  logic            w_rx_state;
  logic            w_accept;
  logic            w_hdr_acc;
  logic            w_byte_en;
  logic            w_start_ok;
  logic            w_word_full;
  logic [31:0]     w_word;

  assign w_rx_state  = (r_state == S_HDR) ||
                       (r_state == S_BYTES);
  assign w_accept    = i_in_valid && w_rx_state;
  assign w_hdr_acc   = w_accept && (r_state == S_HDR);
  assign w_byte_en   = w_accept && (r_state == S_BYTES);
  assign w_start_ok  = i_start &&
                       ((r_state == S_IDLE) ||
                        (r_state == S_DONE));
  assign w_count_inc = r_count + 1'b1;

  // A zero header means a full-depth image
  assign w_hdr_n =
    (i_in_data[ADDR_W-1:0] == '0) ?
    (ADDR_W + 1)'(1 << ADDR_W) :
    {1'b0, i_in_data[ADDR_W-1:0]};

  word_assembler u_asm (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (w_hdr_acc),
    .i_en        (w_byte_en),
    .i_byte      (i_in_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_HDR;
      S_HDR:   if (w_accept) w_next = S_BYTES;
      S_BYTES: if (w_word_full) w_next = S_WRITE;
      S_WRITE: w_next = (w_count_inc == r_target) ?
                        S_DONE : S_BYTES;
      S_DONE:  if (i_start) w_next = S_HDR;
      default: w_next = S_IDLE;
    endcase
  end

  // Word counter and target count
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_target <= '0;
    end else begin
      if (w_start_ok) r_count <= '0;
      if (w_hdr_acc) begin
        r_target <= w_hdr_n;
        r_count  <= '0;
      end
      if (r_state == S_WRITE) r_count <= w_count_inc;
    end
  end

  // Output decode from state only
  always_comb begin
    o_in_ready = 1'b0;
    o_mem_we   = 1'b0;
    o_cpu_hold = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    unique case (r_state)
      S_HDR, S_BYTES: begin
        o_in_ready = 1'b1;
        o_cpu_hold = 1'b1;
        o_busy     = 1'b1;
      end
      S_WRITE: begin
        o_mem_we   = 1'b1;
        o_cpu_hold = 1'b1;
        o_busy     = 1'b1;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_mem_addr     = r_count[ADDR_W-1:0];
  assign o_mem_wdata    = w_word;
  assign o_words_loaded = r_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader.
// Scoreboard of expected writes plus a header vector table.
module tb_instr_mem_loader;

  localparam int AW = 6;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_in_valid = 1'b0;
  logic [7:0]    i_in_data = 8'h00;
  logic          o_in_ready;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic          o_cpu_hold;
  logic          o_busy;
  logic          o_done;
  logic [AW:0]   o_words_loaded;

  instr_mem_loader #(.ADDR_W(AW)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_in_valid     (i_in_valid),
    .i_in_data      (i_in_data),
    .o_in_ready     (o_in_ready),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .o_cpu_hold     (o_cpu_hold),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_words_loaded (o_words_loaded)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];

  always @(negedge i_clk)
    if (o_mem_we === 1'b1)
      obs_q.push_back({o_mem_addr, o_mem_wdata});

  int checks = 0;
  int errors = 0;
  bit start_noise = 1'b0;
  logic [31:0] wbuf[64];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic drain(input string nm);
    wr_t e;
    wr_t o;
    chk({nm, " write count"},
        64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({nm, " addr"}, 64'(o.a), 64'(e.a));
      chk({nm, " data"}, 64'(o.d), 64'(e.d));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gapmax);
    int g;
    int t;
    g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
    repeat (g) @(negedge i_clk);
    i_in_valid = 1'b1;
    i_in_data  = b;
    if (start_noise) i_start = 1'($urandom_range(0, 1));
    t = 0;
    while (o_in_ready !== 1'b1 && t < 200) begin
      @(negedge i_clk);
      if (start_noise) i_start = 1'($urandom_range(0, 1));
      t++;
    end
    if (t >= 200) chk("byte accept timeout", 1, 0);
    @(negedge i_clk);
    i_in_valid = 1'b0;
    i_in_data  = 8'($urandom);
    i_start    = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] hdr,
                         input int n,
                         input int gapmax,
                         input bit do_start,
                         input string nm);
    int t0;
    int t;
    logic ph;
    if (do_start) begin
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
    end
    t0 = cyc;
    chk({nm, " hold in HDR"}, 64'(o_cpu_hold), 1);
    send_byte(hdr, gapmax);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({AW'(i), wbuf[i]});
      for (int k = 0; k < 4; k++)
        send_byte(wbuf[i][8*k +: 8], gapmax);
    end
    t = 0;
    ph = o_cpu_hold;
    while (o_done !== 1'b1 && t < 100) begin
      ph = o_cpu_hold;
      @(negedge i_clk);
      t++;
    end
    if (t >= 100) chk({nm, " done timeout"}, 1, 0);
    chk({nm, " done"}, 64'(o_done), 1);
    chk({nm, " hold low at done"}, 64'(o_cpu_hold), 0);
    chk({nm, " hold high before done"}, 64'(ph), 1);
    chk({nm, " busy"}, 64'(o_busy), 0);
    chk({nm, " words_loaded"},
        64'(o_words_loaded), 64'(n));
    if (gapmax == 0)
      chk({nm, " cycles"}, 64'(cyc - t0),
          64'(1 + 5 * n));
    drain(nm);
  endtask

  typedef struct {
    logic [7:0] hdr;
    int         n;
    int         gap;
  } vec_t;

  vec_t vt[4];

  initial begin
    vt[0] = '{8'h41, 1, 0};
    vt[1] = '{8'hC3, 3, 2};
    vt[2] = '{8'h05, 5, 0};
    vt[3] = '{8'h82, 2, 1};

    // reset with random control activity
    i_rst_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      i_start    = 1'($urandom_range(0, 1));
      i_in_valid = 1'($urandom_range(0, 1));
      i_in_data  = 8'($urandom);
      @(negedge i_clk);
      chk("reset outputs",
          64'({o_in_ready, o_mem_we, o_mem_addr,
               o_mem_wdata, o_cpu_hold, o_busy,
               o_done, o_words_loaded}), 0);
    end
    i_start    = 1'b0;
    i_in_valid = 1'b0;
    i_rst_n    = 1'b1;
    @(negedge i_clk);
    chk("reset no writes", 64'(obs_q.size()), 0);
    chk("idle ready", 64'(o_in_ready), 0);
    obs_q.delete();

    // basic load
    wbuf[0] = 32'h0000_2083;
    wbuf[1] = 32'h0040_2103;
    do_load(8'h02, 2, 0, 1'b1, "basic");

    // same image with source gaps
    do_load(8'h02, 2, 3, 1'b1, "gaps");

    // header decode table
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
      do_load(vt[v].hdr, vt[v].n, vt[v].gap,
              1'b1, $sformatf("vec%0d", v));
    end

    // full depth, value equals address
    for (int i = 0; i < 64; i++) wbuf[i] = 32'(i);
    do_load(8'h00, 64, 0, 1'b1, "full");
    chk("full no wrap addr", 64'(o_mem_addr), 0);

    // start pulses while receiving are ignored
    wbuf[0] = 32'h1234_5678;
    wbuf[1] = 32'h9ABC_DEF0;
    start_noise = 1'b1;
    do_load(8'h02, 2, 0, 1'b1, "start noise");
    start_noise = 1'b0;

    // restart from DONE
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("restart done clear", 64'(o_done), 0);
    chk("restart count clear", 64'(o_words_loaded), 0);
    chk("restart busy", 64'(o_busy), 1);
    wbuf[0] = 32'hCAFE_0001;
    wbuf[1] = 32'hCAFE_0002;
    do_load(8'h02, 2, 0, 1'b0, "reload");

    // reset in the middle of word 1
    wbuf[0] = 32'h1111_1111;
    wbuf[1] = 32'h2222_2222;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    send_byte(8'h02, 0);
    exp_q.push_back({AW'(0), wbuf[0]});
    for (int k = 0; k < 4; k++)
      send_byte(wbuf[0][8*k +: 8], 0);
    send_byte(wbuf[1][7:0], 0);
    send_byte(wbuf[1][15:8], 0);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("midreset outputs",
        64'({o_in_ready, o_mem_we, o_mem_addr,
             o_mem_wdata, o_cpu_hold, o_busy,
             o_done, o_words_loaded}), 0);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("midreset idle", 64'(o_busy), 0);
    drain("midreset");
    wbuf[0] = 32'hDEAD_BEEF;
    do_load(8'h01, 1, 0, 1'b1, "fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
